// File: rtl/input_spi.sv
// Nibble-serial receiver: synchronizes an external sclk/en/data link into clk,
// assembles two nibbles per byte (high first) and buffers bytes in a small FIFO.
module input_spi #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_in,
  input  logic       en_in,
  input  logic [3:0] data_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HI_NIB, LO_NIB} state_e;

  // Synchronizers: all three inputs share the same depth so they stay aligned.
  logic [SYNC_STAGES-1:0]      sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]      en_sync_q, en_sync_d;
  logic [SYNC_STAGES-1:0][3:0] data_sync_q, data_sync_d;
  logic                        sclk_prev_q, sclk_prev_d;
  logic                        en_prev_q, en_prev_d;

  state_e                      state_q, state_d;
  logic [3:0]                  nib_q, nib_d;
  logic                        frame_err_q, frame_err_d;
  logic                        overflow_q, overflow_d;

  logic [FIFO_DEPTH-1:0][7:0]  mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [PW:0]                 count_q, count_d;

  logic                        sclk_s, en_s;
  logic [3:0]                  data_s;
  logic                        link_edge, en_rise, en_fall;
  logic                        push_req, push, pop;
  logic [7:0]                  push_byte;

  always_comb begin
    sclk_sync_d    = sclk_sync_q;
    en_sync_d      = en_sync_q;
    data_sync_d    = data_sync_q;
    sclk_sync_d[0] = sclk_in;
    en_sync_d[0]   = en_in;
    data_sync_d[0] = data_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sclk_sync_d[i] = sclk_sync_q[i-1];
      en_sync_d[i]   = en_sync_q[i-1];
      data_sync_d[i] = data_sync_q[i-1];
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign en_s        = en_sync_q[SYNC_STAGES-1];
  assign data_s      = data_sync_q[SYNC_STAGES-1];
  assign sclk_prev_d = sclk_s;
  assign en_prev_d   = en_s;

  assign link_edge = sclk_s & ~sclk_prev_q & en_s;
  assign en_rise   = en_s & ~en_prev_q;
  assign en_fall   = ~en_s & en_prev_q;

  always_comb begin
    state_d     = state_q;
    nib_d       = nib_q;
    frame_err_d = 1'b0;
    push_req    = 1'b0;
    push_byte   = {nib_q, data_s};
    unique case (state_q)
      IDLE: begin
        if (en_rise) state_d = HI_NIB;
      end
      HI_NIB: begin
        if (en_fall) begin
          state_d = IDLE;
        end else if (link_edge) begin
          nib_d   = data_s;
          state_d = LO_NIB;
        end
      end
      LO_NIB: begin
        if (en_fall) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (link_edge) begin
          push_req = 1'b1;
          state_d  = HI_NIB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign pop  = out_valid & out_ready;
  assign push = push_req & ((count_q != FULL_CNT) | pop);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (push_req & ~push);
    if (push) begin
      mem_d[wr_ptr_q] = push_byte;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      en_sync_q   <= '0;
      data_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      en_prev_q   <= 1'b0;
      state_q     <= IDLE;
      nib_q       <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      en_sync_q   <= en_sync_d;
      data_sync_q <= data_sync_d;
      sclk_prev_q <= sclk_prev_d;
      en_prev_q   <= en_prev_d;
      state_q     <= state_d;
      nib_q       <= nib_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
